// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI byte-stream to register-bank bridge.
// State encodings are fixed so they read the same in waveforms and in the bench.
package spi_reg_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCmd    = 2'b01,
    StWrData = 2'b10,
    StRdData = 2'b11
  } state_e;

  localparam int unsigned CmdWrBit = 7;
  localparam int unsigned AddrW    = 7;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte-level link between the SPI slave shifter (master side) and the bridge.
interface spi_reg_bridge_if;

  logic       ss_in;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;

  modport master (
    output ss_in,
    output rx_rdy,
    output rx_data,
    input  tx_data,
    input  tx_load
  );

  modport slave (
    input  ss_in,
    input  rx_rdy,
    input  rx_data,
    output tx_data,
    output tx_load
  );

endinterface

// File: rtl/spi_reg_bridge_sync_edge.sv
// Two-flop synchroniser; with EdgeOut set, q is instead a registered rising-edge pulse
// of the synchronised level.
module spi_reg_bridge_sync_edge #(
  parameter bit EdgeOut = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  generate
    if (EdgeOut) begin : g_edge
      logic prev_q;
      logic rise_q;

      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= sync_q;
          rise_q <= sync_q & ~prev_q;
        end
      end

      assign q = rise_q;
    end else begin : g_level
      assign q = sync_q;
    end
  endgenerate

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes the SPI byte stream into burst reads/writes of an 8-bit register bank and
// returns readback bytes to the shifter with a one-cycle load strobe.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  spi_reg_bridge_if.slave       bus,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [AddrW-1:0]      wr_addr,
  output logic                  busy
);

  logic ss_sync;
  logic byte_strobe;

  spi_reg_bridge_sync_edge #(
    .EdgeOut (1'b0)
  ) u_sync_ss (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (bus.ss_in),
    .q       (ss_sync)
  );

  spi_reg_bridge_sync_edge #(
    .EdgeOut (1'b1)
  ) u_sync_rdy (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (bus.rx_rdy),
    .q       (byte_strobe)
  );

  state_e           state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_load_q, tx_load_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [AddrW-1:0] wr_addr_q, wr_addr_d;
  logic             reg_we;
  logic [7:0]       regs_q [NUM_REGS];

  logic [7:0] cmd_rd;
  logic [7:0] ptr_rd;
  logic       ptr_in_range;

  // Out-of-range addresses read as zero because no entry matches.
  always_comb begin
    cmd_rd = 8'h00;
    ptr_rd = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rx_data[AddrW-1:0] == AddrW'(i)) cmd_rd = regs_q[i];
      if (ptr_q == AddrW'(i))                  ptr_rd = regs_q[i];
    end
  end

  assign ptr_in_range = 32'(ptr_q) < NUM_REGS;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    reg_we      = 1'b0;

    // Select drop wins over a coincident byte, which is discarded.
    if (!ss_sync) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StCmd;
        StCmd: begin
          if (byte_strobe) begin
            if (bus.rx_data[CmdWrBit]) begin
              ptr_d   = bus.rx_data[AddrW-1:0];
              state_d = StWrData;
            end else begin
              ptr_d     = bus.rx_data[AddrW-1:0] + AddrW'(1);
              tx_data_d = cmd_rd;
              tx_load_d = 1'b1;
              state_d   = StRdData;
            end
          end
        end
        StWrData: begin
          if (byte_strobe) begin
            if (ptr_in_range) begin
              reg_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
            end
            ptr_d = ptr_q + AddrW'(1);
          end
        end
        StRdData: begin
          if (byte_strobe) begin
            tx_data_d = ptr_rd;
            tx_load_d = 1'b1;
            ptr_d     = ptr_q + AddrW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (reg_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ptr_q == AddrW'(i)) regs_q[i] <= bus.rx_data;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[8*g +: 8] = regs_q[g];
    end
  endgenerate

  assign bus.tx_data = tx_data_q;
  assign bus.tx_load = tx_load_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
Consumer stage downstream of the SPI slave byte shifter, clocked on sys_clk. Turns the received byte stream (rx_data plus the rx_rdy level) into register reads and writes on a small register bank. Drives readback bytes plus a load strobe back into the shifter for the next transfer. All SPI-domain inputs are treated as asynchronous and synchronised here.

Parameters:
NUM_REGS, 8, number of 8-bit registers implemented (1..128)
RESET_VAL, 8'h00, reset value of every register

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ss_in  in  1  SPI select from pad; high = transaction active
rx_rdy  in  1  byte-complete level from shifter (async to sys_clk)
rx_data  in  8  received byte, stable while rx_rdy high
tx_data  out  8  byte for shifter to send next
tx_load  out  1  one-cycle strobe: tx_data valid, shifter may latch
regs_flat  out  8*NUM_REGS  register bank, reg[i] at bits [8i+7:8i]
wr_strobe  out  1  one-cycle pulse when a register is written
wr_addr  out  7  address of last write, valid with wr_strobe
busy  out  1  high while in any state other than IDLE

Behaviour:
Reset (async, rst=1): state=IDLE, all regs=RESET_VAL, tx_data=8'h00, tx_load=0, wr_strobe=0, wr_addr=0, busy=0, sync flops=0, addr pointer=0.
Synchronisation:
- ss_in and rx_rdy each pass through a 2-flop synchroniser.
- byte_strobe = synced rx_rdy high AND previous synced value low (registered edge detect).
- Latency: rx_rdy rises before edge N -> byte_strobe high in the cycle after edge N+2 -> the action takes effect at edge N+3.
- rx_data is sampled in the byte_strobe cycle; no separate sync, because it is stable while rx_rdy is high.
Command byte: bit7=1 means write, bit7=0 means read; bits[6:0] give the start address (7-bit addr pointer).
FSM states IDLE, CMD, WR_DATA, RD_DATA:
- IDLE: synced ss=1 -> CMD.
- CMD, on byte_strobe:
  - Write: ptr<=cmd[6:0], go to WR_DATA.
  - Read: ptr<=cmd[6:0]+1, tx_data<=reg[cmd[6:0]], tx_load pulses 1 cycle, go to RD_DATA.
- WR_DATA, on byte_strobe:
  - If ptr<NUM_REGS: reg[ptr]<=rx_data, wr_strobe pulses, wr_addr<=ptr.
  - ptr<=ptr+1 in all cases.
- RD_DATA, on byte_strobe: tx_data<=reg[ptr], tx_load pulses, ptr<=ptr+1. The incoming byte is discarded.
- Any state: synced ss=0 -> IDLE next edge. This overrides a same-cycle byte_strobe; that byte is dropped.
Boundary rules:
- Address >= NUM_REGS: writes are silently dropped with no wr_strobe; reads return 8'h00.
- ptr wraps 127 -> 0 (7-bit arithmetic).
- tx_data holds its value between loads; tx_load never asserts in IDLE, CMD or WR_DATA.
- rst mid-transaction: immediate return to IDLE with all registers at RESET_VAL. A byte_strobe pending in the synchroniser is lost.
- rx_rdy already high when ss rises: no byte_strobe until rx_rdy has gone low and high again.

Decomposition:
Shared package holds the state encoding constants (IDLE=2'b00, CMD=2'b01, WR_DATA=2'b10, RD_DATA=2'b11) and the command bit position CMD_WR_BIT=7.
One sub-module, sync_edge: 2-flop synchroniser with optional rising-edge output, instantiated for ss_in (level) and rx_rdy (edge).

Test Plan:
1. ss=1; bytes 0x83, 0xA5, 0x5A -> reg3=A5 then reg4=5A; wr_strobe twice with wr_addr 3 then 4; byte-to-write latency 3 sys_clk edges from rx_rdy rise.
2. After test 1: ss=1; bytes 0x03, 0xFF -> tx_data=A5 with tx_load pulse after the cmd byte, then tx_data=5A with tx_load after the 2nd byte; regs unchanged.
3. NUM_REGS=8: bytes 0x87, 0x11, 0x22 -> reg7=11; address 8 is dropped with no wr_strobe; all other regs unchanged.
4. ss=1, bytes 0x82, 0x33; ss low for 4 cycles; ss=1, byte 0x02 -> reg2=33; second transaction's first byte decoded as read command; tx_data=33.
5. rst asserted between data bytes of a write burst -> regs back to 00, busy=0 same cycle; next byte after reset release plus ss treated as command.
6. rx_rdy held high across ss rise -> no action until a fresh rx_rdy rise; byte_strobe coincident with ss fall -> byte dropped, state IDLE.
